// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision definitions for the ALU floating-point units.
package fp_pkg;

   localparam int unsigned FP_BIAS = 127;
   localparam int unsigned EXP_W   = 8;
   localparam int unsigned MANT_W  = 23;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [MANT_W-1:0] mant;
   } fp32_t;

   localparam logic [31:0] QNAN = 32'h7FC0_0000;
   localparam logic [31:0] INF  = 32'h7F80_0000;

   typedef enum logic [1:0] {IDLE, DIVIDE, PACK, DONE} div_state_t;

   function automatic logic [31:0] fp_inf(input logic s);
      return INF | {s, 31'b0};
   endfunction

   function automatic logic [31:0] fp_zero(input logic s);
      return {s, 31'b0};
   endfunction

endpackage

// File: rtl/mantissa_divider.sv
// Radix-2 restoring significand divider: one quotient bit per cycle after start.
module mantissa_divider #(
   parameter int unsigned QBITS = 26
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [23:0]      dividend,
   input  logic [23:0]      divisor,
   output logic [QBITS-1:0] q,
   output logic             rem_nz,
   output logic             done
);
   localparam int unsigned CNT_W = $clog2(QBITS + 1);

   logic [24:0]      r_rem;
   logic [QBITS-1:0] r_q;
   logic [CNT_W-1:0] r_cnt;
   logic             r_done;
   logic [25:0]      w_diff;
   logic             w_ge;
   logic             w_unused_msb;

   assign w_diff       = {1'b0, r_rem} - {2'b00, divisor};
   assign w_ge         = ~w_diff[25];
   // A non-negative difference is always below the divisor, so bit 24 is zero.
   assign w_unused_msb = w_diff[24];

   // done is high during the cycle in which the final quotient bit is produced.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rem  <= '0;
         r_q    <= '0;
         r_cnt  <= '0;
         r_done <= 1'b0;
      end else if (start) begin
         r_rem  <= {1'b0, dividend};
         r_q    <= '0;
         r_cnt  <= CNT_W'(QBITS);
         r_done <= 1'b0;
      end else if (r_cnt != '0) begin
         r_q    <= {r_q[QBITS-2:0], w_ge};
         r_rem  <= w_ge ? {w_diff[23:0], 1'b0} : {r_rem[23:0], 1'b0};
         r_cnt  <= r_cnt - 1'b1;
         r_done <= (r_cnt == CNT_W'(2));
      end
   end

   assign q      = r_q;
   assign rem_nz = |r_rem;
   assign done   = r_done;

endmodule

// File: rtl/fp_divider.sv
// Sequential IEEE-754 single-precision divider with valid/ready on both sides.
// FP_DIV_ROUND_EN selects round-to-nearest-even; otherwise results truncate.
module fp_divider
   import fp_pkg::*;
#(
   parameter int unsigned QBITS = 26
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in1,
   input  logic [31:0] in2,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out,
   output logic        div_by_zero
);
   div_state_t         r_state;
   logic               r_sign;
   logic signed [9:0]  r_exp;
   logic [23:0]        r_mb;
   logic               r_special;
   logic [31:0]        r_spec_res;
   logic               r_spec_dz;
   logic [31:0]        r_res;
   logic               r_res_dz;

   fp32_t              w_a;
   fp32_t              w_b;
   logic               w_sign;
   logic               w_a_zero, w_a_inf, w_a_nan;
   logic               w_b_zero, w_b_inf, w_b_nan;
   logic signed [9:0]  w_exp;
   logic               w_special;
   logic               w_spec_dz;
   logic [31:0]        w_spec_res;
   logic               w_start;
   logic [QBITS-1:0]   w_q;
   logic               w_rem_nz;
   logic               w_done;
   logic [MANT_W-1:0]  w_mant;
   logic               w_guard;
   logic               w_sticky;
   logic signed [9:0]  w_exp_n;
   logic               w_inc;
   logic               w_carry;
   logic [MANT_W-1:0]  w_mant_rnd;
   logic signed [9:0]  w_exp_rnd;
   logic [31:0]        w_pack;

   assign w_a      = in1;
   assign w_b      = in2;
   assign w_sign   = w_a.sign ^ w_b.sign;
   // Denormals (exp == 0) are treated as zero.
   assign w_a_zero = (w_a.exp == '0);
   assign w_b_zero = (w_b.exp == '0);
   assign w_a_inf  = (&w_a.exp) & (w_a.mant == '0);
   assign w_b_inf  = (&w_b.exp) & (w_b.mant == '0);
   assign w_a_nan  = (&w_a.exp) & (|w_a.mant);
   assign w_b_nan  = (&w_b.exp) & (|w_b.mant);
   assign w_exp    = $signed({2'b00, w_a.exp}) - $signed({2'b00, w_b.exp})
                   + $signed(10'(FP_BIAS));

   // Special operand classes bypass the iterative core.
   always_comb begin
      w_special  = 1'b1;
      w_spec_dz  = 1'b0;
      w_spec_res = QNAN;
      if (w_a_nan | w_b_nan | (w_a_zero & w_b_zero) | (w_a_inf & w_b_inf)) begin
         w_spec_res = QNAN;
      end else if (w_b_zero) begin
         w_spec_res = fp_inf(w_sign);
         w_spec_dz  = 1'b1;
      end else if (w_a_inf) begin
         w_spec_res = fp_inf(w_sign);
      end else if (w_a_zero | w_b_inf) begin
         w_spec_res = fp_zero(w_sign);
      end else begin
         w_special  = 1'b0;
      end
   end

   assign w_start = (r_state == IDLE) & in_valid & ~w_special;

   mantissa_divider #(.QBITS(QBITS)) u_mdiv (
      .clk      (clk),
      .rst      (rst),
      .start    (w_start),
      .dividend ({1'b1, w_a.mant}),
      .divisor  (r_mb),
      .q        (w_q),
      .rem_nz   (w_rem_nz),
      .done     (w_done)
   );

   // Normalise: a quotient below 1.0 shifts left one place and costs an exponent step.
   always_comb begin
      w_mant   = '0;
      w_guard  = 1'b0;
      w_sticky = 1'b0;
      w_exp_n  = r_exp;
      if (w_q[QBITS-1]) begin
         w_mant   = w_q[QBITS-2:2];
         w_guard  = w_q[1];
         w_sticky = w_q[0] | w_rem_nz;
      end else begin
         w_mant   = w_q[QBITS-3:1];
         w_guard  = w_q[0];
         w_sticky = w_rem_nz;
         w_exp_n  = r_exp - 10'sd1;
      end
   end

`ifdef FP_DIV_ROUND_EN
   assign w_inc = w_guard & (w_sticky | w_mant[0]);
`else
   logic w_unused_rnd;
   assign w_inc        = 1'b0;
   assign w_unused_rnd = &{1'b0, w_guard, w_sticky};
`endif

   assign {w_carry, w_mant_rnd} = {1'b0, w_mant} + 24'(w_inc);
   assign w_exp_rnd = w_exp_n + $signed({9'b0, w_carry});

   always_comb begin
      if (w_exp_rnd >= 10'sd255) begin
         w_pack = fp_inf(r_sign);
      end else if (w_exp_rnd <= 10'sd0) begin
         w_pack = fp_zero(r_sign);
      end else begin
         w_pack = {r_sign, w_exp_rnd[7:0], w_mant_rnd};
      end
   end

   // Control FSM; DONE spends its first cycle presenting the packed result.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         out         <= '0;
         div_by_zero <= 1'b0;
         r_sign      <= 1'b0;
         r_exp       <= '0;
         r_mb        <= '0;
         r_special   <= 1'b0;
         r_spec_res  <= '0;
         r_spec_dz   <= 1'b0;
         r_res       <= '0;
         r_res_dz    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_sign     <= w_sign;
                  r_exp      <= w_exp;
                  r_mb       <= {1'b1, w_b.mant};
                  r_special  <= w_special;
                  r_spec_res <= w_spec_res;
                  r_spec_dz  <= w_spec_dz;
                  in_ready   <= 1'b0;
                  r_state    <= w_special ? PACK : DIVIDE;
               end
            end
            DIVIDE: begin
               if (w_done) r_state <= PACK;
            end
            PACK: begin
               r_res    <= r_special ? r_spec_res : w_pack;
               r_res_dz <= r_special & r_spec_dz;
               r_state  <= DONE;
            end
            DONE: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  r_state   <= IDLE;
               end else if (!out_valid) begin
                  out_valid   <= 1'b1;
                  out         <= r_res;
                  div_by_zero <= r_res_dz;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
